// File: rtl/acc_datapath.sv
// acc_datapath: WIDTH-bit accumulator with an 8-op ALU, valid/ready op handshake and a multi-cycle shift-and-add MUL.
// Ports: clk, rst (sync, active-high); op_valid/op_ready handshake; oc (opcode) and operand sampled at accept;
// acc (registered accumulator); done (one-cycle pulse after each completed op); z/n flags from acc; c (registered carry).
// Build option ACC_SAT_EN: ADD saturates to all-ones on carry, SUB clamps to zero on borrow.
module acc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       oc,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             z,
  output logic             n,
  output logic             c
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mplier_q, mplier_d, alu_r;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] sum, dif;
  logic c_q, c_d, wr_q, wr_d, done_q, done_d, alu_c, accept;
  assign op_ready = state_q == IDLE;
  assign accept = op_valid && op_ready;
  assign acc = acc_q;
  assign c = c_q;
  assign done = done_q;
  assign z = acc_q == '0;
  assign n = acc_q[WIDTH-1];
  assign sum = {1'b0, acc_q} + {1'b0, operand};
  assign dif = {1'b0, acc_q} - {1'b0, operand};
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (oc)
      3'd0: alu_r = operand;
`ifdef ACC_SAT_EN
      3'd1: {alu_c, alu_r} = {sum[WIDTH], sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0]};
      3'd2: {alu_c, alu_r} = {dif[WIDTH], dif[WIDTH] ? {WIDTH{1'b0}} : dif[WIDTH-1:0]};
`else
      3'd1: {alu_c, alu_r} = sum;
      3'd2: {alu_c, alu_r} = dif;
`endif
      3'd3: alu_r = acc_q & operand;
      3'd4: alu_r = acc_q | operand;
      3'd5: alu_r = acc_q ^ operand;
      3'd6: {alu_c, alu_r} = operand[0] ? {acc_q[0], acc_q >> 1} : {acc_q[WIDTH-1], acc_q << 1};
      default: ;
    endcase
  end
  // done trails the acc/c write by one cycle, so it is registered from the write strobe.
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    c_d = c_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    cnt_d = cnt_q;
    wr_d = 1'b0;
    done_d = wr_q;
    if (state_q == IDLE) begin
      if (accept && oc == 3'd7) begin
        mcand_d = {{WIDTH{1'b0}}, acc_q};
        mplier_d = operand;
        prod_d = '0;
        cnt_d = '0;
        state_d = MUL;
      end else if (accept) begin
        acc_d = alu_r;
        c_d = alu_c;
        wr_d = 1'b1;
      end
    end else begin
      prod_d = prod_nx;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        acc_d = prod_nx[WIDTH-1:0];
        c_d = |prod_nx[2*WIDTH-1:WIDTH];
        wr_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      c_q <= 1'b0;
      mcand_q <= '0;
      mplier_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      c_q <= c_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_acc_datapath.sv
// tb_acc_datapath: directed bench for acc_datapath with a cycle-level reference model and per-cycle comparison.
module tb_acc_datapath;
  localparam int W = 8;
  logic clk = 0, rst = 1, op_valid = 0, op_ready, done, z, n, c;
  logic [2:0] oc = 0;
  logic [W-1:0] operand = 0, acc;
  int checks = 0, errors = 0;
  acc_datapath #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .oc(oc),
    .operand(operand), .acc(acc), .done(done), .z(z), .n(n), .c(c));
  always #5 clk = ~clk;
  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  localparam longint M = longint'(1) << W;
  function automatic void model_op(input int o, input longint a, input longint b, output longint r, output bit cy);
    r = 0;
    cy = 0;
    case (o)
      0: r = b;
      1: begin r = a + b; cy = r >= M; r = r % M;
`ifdef ACC_SAT_EN
        if (cy) r = M - 1;
`endif
      end
      2: begin cy = b > a; r = (a - b + M) % M;
`ifdef ACC_SAT_EN
        if (cy) r = 0;
`endif
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: if (b % 2 == 1) begin r = a / 2; cy = a % 2 == 1; end
         else begin r = (a * 2) % M; cy = a >= M / 2; end
      default: ;
    endcase
  endfunction
  logic [W-1:0] m_acc;
  bit m_c, m_wr, m_done;
  int m_busy;
  longint m_prod;
  always @(posedge clk) begin
    longint r;
    bit cy;
    if (rst) begin
      m_acc <= 0; m_c <= 0; m_wr <= 0; m_done <= 0; m_busy <= 0;
    end else begin
      m_done <= m_wr;
      m_wr <= 0;
      if (m_busy == 0 && op_valid) begin
        if (oc == 3'd7) begin
          m_busy <= W;
          m_prod <= longint'(m_acc) * longint'(operand);
        end else begin
          model_op(int'(oc), longint'(m_acc), longint'(operand), r, cy);
          m_acc <= r[W-1:0];
          m_c <= cy;
          m_wr <= 1;
        end
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_acc <= m_prod[W-1:0];
          m_c <= m_prod >= M;
          m_wr <= 1;
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    check("acc", acc, m_acc);
    check("c", c, m_c);
    check("z", z, m_acc == 0);
    check("n", n, m_acc[W-1]);
    check("op_ready", op_ready, m_busy == 0);
    check("done", done, m_done);
  end
  task automatic issue(input logic [2:0] o, input logic [W-1:0] b);
    int g = 0;
    while (!op_ready && g < 100) begin @(negedge clk); g++; end
    check("ready_wait", op_ready, 1);
    op_valid = 1; oc = o; operand = b;
  endtask
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] b, output int lat, output int busy);
    issue(o, b);
    @(negedge clk);
    op_valid = 0;
    lat = 0;
    busy = op_ready ? 0 : 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!op_ready) busy++;
    end
    check("done_timeout", done, 1);
  endtask
  initial begin
    int lat, busy, g;
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, busy, g;
    @(negedge clk);
    rst = 0;
    check("rst_acc", acc, 0); check("rst_z", z, 1); check("rst_n", n, 0);
    check("rst_c", c, 0); check("rst_ready", op_ready, 1); check("rst_done", done, 0);
    run_op(0, 8'hF0, lat, busy);
    check("load_lat", lat, 1);
    run_op(1, 8'h20, lat, busy);
    check("add_lat", lat, 1);
`ifdef ACC_SAT_EN
    check("add_acc", acc, 8'hFF);
`else
    check("add_acc", acc, 8'h10);
`endif
    check("add_c", c, 1);
    run_op(0, 8'h03, lat, busy);
    run_op(2, 8'h05, lat, busy);
`ifdef ACC_SAT_EN
    check("sub_acc", acc, 8'h00);
    check("sub_n", n, 0);
`else
    check("sub_acc", acc, 8'hFE);
    check("sub_n", n, 1);
`endif
    check("sub_c", c, 1);
    run_op(0, 8'hFE, lat, busy);
    run_op(6, 8'h00, lat, busy);
    check("shl_acc", acc, 8'hFC); check("shl_c", c, 1);
    run_op(6, 8'h01, lat, busy);
    check("shr_acc", acc, 8'h7E); check("shr_c", c, 0);
    run_op(0, 8'hCA, lat, busy);
    run_op(3, 8'h0F, lat, busy); check("and_acc", acc, 8'h0A);
    run_op(4, 8'h50, lat, busy); check("or_acc", acc, 8'h5A);
    run_op(5, 8'hFF, lat, busy); check("xor_acc", acc, 8'hA5);
    run_op(0, 8'd12, lat, busy);
    run_op(7, 8'd13, lat, busy);
    check("mul_lat", lat, W + 1); check("mul_busy", busy, W);
    check("mul_acc", acc, 8'h9C); check("mul_c", c, 0);
    // back-to-back single-cycle ops, one accept per cycle
    issue(0, 8'h01);
    @(negedge clk); oc = 1; operand = 8'h02;
    @(negedge clk); oc = 1; operand = 8'h04;
    @(negedge clk); op_valid = 0;
    check("b2b_done", done, 1);
    @(negedge clk);
    check("b2b_acc", acc, 8'h07);
    // MUL with a request held during busy
    run_op(0, 8'h20, lat, busy);
    issue(7, 8'h10);
    @(negedge clk);
    oc = 1; operand = 8'h01;
    g = 0;
    while (!op_ready && g < 100) begin @(negedge clk); g++; end
    check("held_acc", acc, 8'h00); check("held_z", z, 1); check("held_c", c, 1);
    @(negedge clk);
    op_valid = 0;
    check("held_muldone", done, 1);
    check("held_add_acc", acc, 8'h01);
    @(negedge clk); @(negedge clk);
    check("held_once", acc, 8'h01);
    // reset during MUL
    run_op(0, 8'h05, lat, busy);
    issue(7, 8'h03);
    @(negedge clk); op_valid = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mulrst_acc", acc, 0); check("mulrst_ready", op_ready, 1);
    g = 0;
    repeat (W + 3) begin @(negedge clk); if (done) g++; end
    check("mulrst_nodone", g, 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
